// File: rtl/compensation_loader.sv
// compensation_loader
// Unpacks a byte stream of 4-bit compensation weights (low nibble first) and
// writes them to the compensation memory at ascending addresses
// 0..CMEM_SIZE-1, then pulses done for one cycle.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready are
// both high during the preceding cycle. in_ready depends only on registered
// state, never on in_valid, so the producer may hold or drop in_valid freely;
// dropping it only delays the next transfer.
module compensation_loader #(
    parameter int SIZE            = 8,
    parameter int CMEM_SIZE       = SIZE * 3,
    parameter int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 Compensation_Weight,
    output logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr,
    output logic                       Wr_en,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CMEM_ADDR_WIDTH-1:0] LAST_ADDR = CMEM_ADDR_WIDTH'(CMEM_SIZE - 1);
    localparam logic [CMEM_ADDR_WIDTH-1:0] ONE       = CMEM_ADDR_WIDTH'(1);

    state_t                     r_state;
    logic [CMEM_ADDR_WIDTH-1:0] r_cnt;
    logic                       r_hi_pending;
    logic [3:0]                 r_hi_buf;
    logic [3:0]                 r_weight;
    logic [CMEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic                       r_wr_en;
    logic                       r_busy;
    logic                       r_done;
    // Set once the write to the last address has been issued; blocks any
    // further transfer in the single cycle before the FSM moves to DONE.
    logic                       r_last_issued;

    logic                       w_in_ready;

    // Accept a byte only in LOAD, with no high nibble waiting and the final
    // address not yet issued.
    assign w_in_ready = (r_state == S_LOAD) && !r_hi_pending && !r_last_issued;

    assign in_ready            = w_in_ready;
    assign Compensation_Weight = r_weight;
    assign Wr_Addr             = r_wr_addr;
    assign Wr_en               = r_wr_en;
    assign busy                = r_busy;
    assign done                = r_done;
    assign dbg_state           = r_state;

    // Session FSM: unpack bytes into one write per cycle and sequence the
    // address counter; all memory-side outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hi_pending  <= 1'b0;
            r_hi_buf      <= '0;
            r_weight      <= '0;
            r_wr_addr     <= '0;
            r_wr_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_last_issued <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt         <= '0;
                        r_hi_pending  <= 1'b0;
                        r_last_issued <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_last_issued) begin
                        r_last_issued <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (r_hi_pending) begin
                        // Second nibble of the previous byte goes out now.
                        r_wr_en      <= 1'b1;
                        r_weight     <= r_hi_buf;
                        r_wr_addr    <= r_cnt;
                        r_hi_pending <= 1'b0;
                        if (r_cnt == LAST_ADDR) begin
                            r_last_issued <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end else if (in_valid) begin
                        // in_ready is high here, so in_valid means a transfer.
                        r_wr_en   <= 1'b1;
                        r_weight  <= in_data[3:0];
                        r_wr_addr <= r_cnt;
                        r_hi_buf  <= in_data[7:4];
                        if (r_cnt == LAST_ADDR) begin
                            // Odd entry count: the upper nibble is dropped.
                            r_last_issued <= 1'b1;
                        end else begin
                            r_cnt        <= r_cnt + ONE;
                            r_hi_pending <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compensation_loader.sv
// tb_compensation_loader
// Two loader instances (24 entries and 9 entries) share clock, reset and the
// byte stream; each has its own start. A monitor logs every write and done
// pulse; each test compares the logs against a model built from the bytes
// actually accepted.
module tb_compensation_loader;

    localparam int CMEM_A = 24;
    localparam int CMEM_B = 9;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start_a  = 1'b0;
    logic       start_b  = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;

    logic       in_ready_a, in_ready_b;
    logic [3:0] wt_a, wt_b;
    logic [4:0] addr_a;
    logic [3:0] addr_b;
    logic       wr_en_a, wr_en_b, busy_a, busy_b, done_a, done_b;
    logic [1:0] st_a, st_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ts     = 0;

    // write / done logs filled by the monitor
    int a_addr[$], a_wt[$], a_cyc[$], a_done[$], a_dbusy[$];
    int b_addr[$], b_wt[$], b_cyc[$], b_done[$], b_dbusy[$];

    // driver bookkeeping
    logic [7:0] tx_q[$];
    logic [7:0] sent_q[$];
    int         fire_cyc[$];

    compensation_loader #(.SIZE(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .Compensation_Weight(wt_a), .Wr_Addr(addr_a),
        .Wr_en(wr_en_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );

    compensation_loader #(.SIZE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .Compensation_Weight(wt_b), .Wr_Addr(addr_b),
        .Wr_en(wr_en_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en_a) begin
            a_addr.push_back(int'(addr_a)); a_wt.push_back(int'(wt_a)); a_cyc.push_back(cyc);
        end
        if (done_a) begin
            a_done.push_back(cyc); a_dbusy.push_back(int'(busy_a));
        end
        if (wr_en_b) begin
            b_addr.push_back(int'(addr_b)); b_wt.push_back(int'(wt_b)); b_cyc.push_back(cyc);
        end
        if (done_b) begin
            b_done.push_back(cyc); b_dbusy.push_back(int'(busy_b));
        end
    end

    task automatic clear_logs();
        a_addr.delete(); a_wt.delete(); a_cyc.delete(); a_done.delete(); a_dbusy.delete();
        b_addr.delete(); b_wt.delete(); b_cyc.delete(); b_done.delete(); b_dbusy.delete();
        sent_q.delete(); fire_cyc.delete();
    endtask

    // Driver: pulse start, then present tx_q bytes with random bubbles.
    task automatic run_session(input bit sel, input int ncyc, input int bubble_pct,
                               input int restart_at, input int abort_addr, output bit aborted);
        bit fire;
        aborted = 1'b0;
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        in_valid = 1'b0;
        ts = cyc + 1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            fire = in_valid && (sel ? in_ready_b : in_ready_a);
            if (fire) begin
                fire_cyc.push_back(cyc);
                sent_q.push_back(in_data);
            end
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            if (fire) void'(tx_q.pop_front());
            if (c == restart_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (tx_q.size() > 0 && int'($urandom_range(0, 99)) >= bubble_pct) begin
                in_valid = 1'b1;
                in_data  = tx_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            if (abort_addr >= 0 &&
                (sel ? (wr_en_b && int'(addr_b) == abort_addr)
                     : (wr_en_a && int'(addr_a) == abort_addr))) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) in_valid = 1'b0;
    endtask

    // Scoreboard for one finished session on instance sel.
    task automatic score_session(input bit sel, input int cmem, input bit b2b, input string tag);
        logic [11:0] exp_q[$];
        logic [11:0] got;
        logic [7:0]  byt;
        logic [3:0]  nib;
        int addr_q[$], wt_q[$], cyc_q[$], done_q[$], dbusy_q[$];
        int other_n, n;
        logic fin_busy, fin_rdy;
        if (sel) begin
            addr_q = b_addr; wt_q = b_wt; cyc_q = b_cyc; done_q = b_done; dbusy_q = b_dbusy;
            other_n = a_addr.size() + a_done.size();
            fin_busy = busy_b; fin_rdy = in_ready_b;
        end else begin
            addr_q = a_addr; wt_q = a_wt; cyc_q = a_cyc; done_q = a_done; dbusy_q = a_dbusy;
            other_n = b_addr.size() + b_done.size();
            fin_busy = busy_a; fin_rdy = in_ready_a;
        end
        // reference: nibbles of accepted bytes, low first, one per address
        n = 0;
        foreach (sent_q[k]) begin
            byt = sent_q[k];
            for (int h = 0; h < 2; h++) begin
                nib = (h == 0) ? byt[3:0] : byt[7:4];
                if (n < cmem) begin
                    exp_q.push_back({8'(n), nib});
                    n++;
                end
            end
        end
        checks++;
        if (sent_q.size() != (cmem + 1) / 2) begin
            errors++;
            $display("FAIL %s bytes_accepted got %0d exp %0d", tag, sent_q.size(), (cmem + 1) / 2);
        end
        checks++;
        if (addr_q.size() != cmem) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", tag, addr_q.size(), cmem);
        end
        for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++) begin
            got = {8'(addr_q[i]), 4'(wt_q[i])};
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write[%0d] addr/wt got %03h exp %03h", tag, i, got, exp_q[i]);
            end
        end
        for (int i = 0; i < cyc_q.size() && i / 2 < fire_cyc.size(); i++) begin
            checks++;
            if (cyc_q[i] != fire_cyc[i / 2] + 1 + (i % 2)) begin
                errors++;
                $display("FAIL %s write[%0d] cycle got %0d exp %0d", tag, i, cyc_q[i],
                         fire_cyc[i / 2] + 1 + (i % 2));
            end
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_pulses got %0d exp 1", tag, done_q.size());
        end
        if (done_q.size() > 0 && cyc_q.size() > 0) begin
            checks++;
            if (done_q[0] != cyc_q[cyc_q.size() - 1] + 1) begin
                errors++;
                $display("FAIL %s done_cycle got %0d exp %0d", tag, done_q[0], cyc_q[cyc_q.size() - 1] + 1);
            end
            checks++;
            if (dbusy_q[0] != 1) begin
                errors++;
                $display("FAIL %s busy_at_done got %0d exp 1", tag, dbusy_q[0]);
            end
        end
        if (b2b) begin
            checks++;
            if (fire_cyc.size() == 0 || fire_cyc[0] != ts) begin
                errors++;
                $display("FAIL %s first_transfer got %0d exp %0d", tag,
                         (fire_cyc.size() > 0) ? fire_cyc[0] : -1, ts);
            end
            checks++;
            if (cyc_q.size() == 0 || cyc_q[cyc_q.size() - 1] != ts + cmem) begin
                errors++;
                $display("FAIL %s last_write_cycle got %0d exp %0d", tag,
                         (cyc_q.size() > 0) ? cyc_q[cyc_q.size() - 1] : -1, ts + cmem);
            end
        end
        checks++;
        if (other_n != 0) begin
            errors++;
            $display("FAIL %s other_instance_activity got %0d exp 0", tag, other_n);
        end
        checks++;
        if ({fin_busy, fin_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL %s end_busy_ready got %b exp 00", tag, {fin_busy, fin_rdy});
        end
    endtask

    task automatic test_reset();
        clear_logs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_en_a, busy_a, done_a, in_ready_a, wt_a, addr_a, st_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a got %h exp 0", {wr_en_a, busy_a, done_a, in_ready_a, wt_a, addr_a, st_a});
        end
        checks++;
        if ({wr_en_b, busy_b, done_b, in_ready_b, wt_b, addr_b, st_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b got %h exp 0", {wr_en_b, busy_b, done_b, in_ready_b, wt_b, addr_b, st_b});
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            checks++;
            if ({in_ready_a, in_ready_b, busy_a, busy_b, st_a, st_b} !== '0) begin
                errors++;
                $display("FAIL idle_ready_busy cyc %0d got %b exp 0", c,
                         {in_ready_a, in_ready_b, busy_a, busy_b, st_a, st_b});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (a_addr.size() + b_addr.size() + a_done.size() + b_done.size() != 0) begin
            errors++;
            $display("FAIL idle_writes got %0d exp 0", a_addr.size() + b_addr.size() + a_done.size() + b_done.size());
        end
    endtask

    task automatic test_full_load();
        bit ab;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 12; k++) tx_q.push_back({4'(2 * k + 1), 4'(2 * k)});
        for (int k = 0; k < 4; k++) tx_q.push_back(8'($urandom));
        run_session(1'b0, 40, 0, -1, -1, ab);
        score_session(1'b0, CMEM_A, 1'b1, "full");
        for (int i = 0; i < a_wt.size(); i++) begin
            checks++;
            if (a_wt[i] != i % 16) begin
                errors++;
                $display("FAIL full weight_pattern[%0d] got %0d exp %0d", i, a_wt[i], i % 16);
            end
        end
    endtask

    task automatic test_odd_size();
        bit ab;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 4; k++) tx_q.push_back(8'($urandom));
        tx_q.push_back(8'hF8);
        for (int k = 0; k < 2; k++) tx_q.push_back(8'($urandom));
        run_session(1'b1, 24, 0, -1, -1, ab);
        score_session(1'b1, CMEM_B, 1'b1, "odd");
        checks++;
        if (b_addr.size() == 0 || b_addr[b_addr.size() - 1] != 8 || b_wt[b_wt.size() - 1] != 8) begin
            errors++;
            $display("FAIL odd last_write got addr %0d wt %0d exp addr 8 wt 8",
                     (b_addr.size() > 0) ? b_addr[b_addr.size() - 1] : -1,
                     (b_wt.size() > 0) ? b_wt[b_wt.size() - 1] : -1);
        end
    endtask

    task automatic test_bubbles();
        bit ab;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 14; k++) tx_q.push_back(8'($urandom));
        run_session(1'b0, 150, 40, -1, -1, ab);
        score_session(1'b0, CMEM_A, 1'b0, "bubbles");
    endtask

    task automatic test_start_while_busy();
        bit ab;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 14; k++) tx_q.push_back(8'($urandom));
        run_session(1'b0, 40, 0, 4, -1, ab);
        score_session(1'b0, CMEM_A, 1'b1, "restart");
    endtask

    task automatic test_reset_mid();
        bit ab;
        int abort_cyc, late;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 16; k++) tx_q.push_back(8'($urandom));
        run_session(1'b0, 40, 0, -1, 10, ab);
        checks++;
        if (!ab) begin
            errors++;
            $display("FAIL midreset addr10_seen got 0 exp 1");
        end
        #2;
        rst = 1'b0;
        #1;
        abort_cyc = cyc;
        checks++;
        if ({wr_en_a, busy_a, in_ready_a, done_a} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset async_outputs got %b exp 0000", {wr_en_a, busy_a, in_ready_a, done_a});
        end
        repeat (3) @(negedge clk);
        late = 0;
        foreach (a_cyc[i]) if (a_cyc[i] >= abort_cyc) late++;
        checks++;
        if (late != 0 || a_done.size() != 0) begin
            errors++;
            $display("FAIL midreset writes_after_reset got %0d done %0d exp 0 0", late, a_done.size());
        end
        checks++;
        if (a_addr.size() != 10) begin
            errors++;
            $display("FAIL midreset writes_before_reset got %0d exp 10", a_addr.size());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        clear_logs();
        tx_q.delete();
        for (int k = 0; k < 14; k++) tx_q.push_back(8'($urandom));
        run_session(1'b0, 40, 0, -1, -1, ab);
        score_session(1'b0, CMEM_A, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        bit ab, sel;
        int cmem, pct;
        for (int r = 0; r < 4; r++) begin
            sel  = 1'($urandom_range(0, 1));
            cmem = sel ? CMEM_B : CMEM_A;
            pct  = (r == 0) ? 0 : int'($urandom_range(0, 60));
            clear_logs();
            tx_q.delete();
            for (int k = 0; k < (cmem + 1) / 2 + 3; k++) tx_q.push_back(8'($urandom));
            run_session(sel, 220, pct, -1, -1, ab);
            score_session(sel, cmem, pct == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_odd_size();
        test_bubbles();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compensation_loader.md
# compensation_loader

Streams 4-bit compensation weights into the compensation memory before a systolic-array pass. It accepts a byte stream over a valid/ready handshake; each byte carries two weights, low nibble first. It unpacks the stream and drives the memory write port with sequential addresses 0..CMEM_SIZE-1, then signals completion. It sits between the pre-load unit's data path and the compensation memory write port.

## Interface
- SIZE, 8, systolic array dimension (number of compensation banks)
- CMEM_SIZE, SIZE*3, total compensation entries to load per session
- CMEM_ADDR_WIDTH, $clog2(CMEM_SIZE), write address width
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a load session
- in_data  input  8  packed weights: [3:0] first weight, [7:4] second weight
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept in_data this cycle
- Compensation_Weight  output  4  weight to memory, registered
- Wr_Addr  output  CMEM_ADDR_WIDTH  memory write address, registered
- Wr_en  output  1  memory write strobe, registered
- busy  output  1  load session in progress
- done  output  1  one-cycle pulse after the final write

## Operation
- FSM states: IDLE, LOAD, DONE.
- Address counter cnt runs 0..CMEM_SIZE-1. One-bit hi_pending flag and a 4-bit hi_buf hold the second nibble.
- IDLE: in_ready=0, Wr_en=0. A start pulse clears cnt and hi_pending and moves to LOAD.
- LOAD, handshake: in_ready = (state==LOAD) && !hi_pending. Transfer occurs when in_valid && in_ready.
- LOAD, on transfer:
  - Next cycle: Wr_en=1, Compensation_Weight=in_data[3:0], Wr_Addr=cnt, and cnt increments.
  - hi_buf <= in_data[7:4].
  - hi_pending <= 1, unless cnt==CMEM_SIZE-1. In that case in_data[7:4] is discarded; this happens when CMEM_SIZE is odd.
- LOAD, when hi_pending=1:
  - Next cycle: Wr_en=1, Compensation_Weight=hi_buf, Wr_Addr=cnt, and cnt increments.
  - hi_pending <= 0.
- Cycles with no transfer and no pending nibble: Wr_en=0. Compensation_Weight and Wr_Addr hold their last values.
- LOAD exits to DONE in the cycle after the write to CMEM_SIZE-1 is issued.
- DONE lasts one cycle: done=1, then the FSM returns to IDLE.
- busy=1 in LOAD and DONE, 0 in IDLE.
- start while busy is ignored. It does not restart the session or reset cnt.
- in_valid while in IDLE or DONE is ignored. No transfer occurs because in_ready=0.
- Address arithmetic is unsigned and never exceeds CMEM_SIZE-1. No wrap within a session.
- Each address is written exactly once per session, in ascending order.

## Timing
- Reset values (rst low, async): state=IDLE, cnt=0, hi_pending=0, hi_buf=0, Compensation_Weight=0, Wr_Addr=0, Wr_en=0, busy=0, done=0, in_ready=0.
- Reset asserted mid-session abandons the session immediately. No further Wr_en follows. The next session requires a new start.
- Start accepted at edge T: LOAD in cycle T+1, with busy=1 and in_ready=1.
- Transfer at cycle t:
  - Low-nibble write strobe in cycle t+1; in_ready=0 in t+1.
  - High-nibble write in cycle t+2; in_ready=1 again in t+2.
- Peak throughput: one byte per 2 cycles, one write per cycle, Wr_en continuously high under back-to-back valid.
- Final write in cycle L: done=1 and busy=1 in L+1; busy=0 and in_ready=0 in L+2.
- With in_valid held high, total session length from the start edge is CMEM_SIZE+2 cycles.
- in_valid deassertion stalls only new transfers. A pending high nibble is still written the following cycle.

## Test plan
- Reset then idle: rst low then high, in_valid=1 with no start. Required: Wr_en never asserts, in_ready=0, all outputs 0.
- Full load, SIZE=8: start, then 12 back-to-back bytes 0x10, 0x32, ..., 0xBA, ... (byte k = {2k+1, 2k} mod 16). Required:
  - Wr_en high for 24 consecutive cycles.
  - Wr_Addr 0..23 with weight = addr mod 16.
  - done pulses once, 1 cycle after addr 23.
- Odd size, SIZE=3 (CMEM_SIZE=9): 5 bytes, last byte 0xF8. Required: addr 8 is written with 0x8, 0xF is never written, exactly 9 writes, done follows.
- Bubbles: in_valid toggled 1,0,0,1 between bytes. Required:
  - High nibble is still written the cycle after its low nibble.
  - Wr_en gaps appear only during input bubbles.
  - Addresses stay contiguous; no duplicates.
- Start while busy: start pulsed after 3 writes. Required: cnt is not reset, the sequence continues at address 3, and only one done pulse.
- Reset mid-session: rst low after write to addr 10. Required:
  - Wr_en=0 asynchronously, busy=0, no done.
  - A new start reloads from addr 0.
